sm3_hash_store: RTL and testbench

Downstream writeback stage for the SM3 hashing core. It captures the 256-bit digest when the core asserts its save-hash level. It then serialises the digest into eight 32-bit data-memory writes at a caller-supplied base address, using a valid/ready handshake. While the transfer is in progress it holds the CPU pipeline and emits a one-cycle completion pulse at the end.

---
 rtl/sm3_hash_store.sv | 112 +++++++++++
 tb/tb_sm3_hash_store.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_hash_store.sv
// sm3_hash_store: captures an SM3 digest on a rising save_hash and writes it
// to data memory as eight 32-bit words (word A first) over a valid/ready
// handshake, stalling the CPU pipeline until the last word is accepted.
module sm3_hash_store #(
    parameter int NUM_WORDS   = 8,
    parameter int ADDR_STRIDE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         save_hash,
    input  logic [255:0] hash_value,
    input  logic [31:0]  dst_addr,
    input  logic         mem_ready,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         hold_pipeline,
    output logic         done,
    output logic         overrun
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               save_q;
    logic [255:0]       digest_q, digest_d;
    logic [31:0]        base_q, base_d;
    logic               cap;

    // Rising edge of the save level; a level held high never retriggers.
    assign cap = save_hash & ~save_q;

    // State, word index, edge-detect history and captured transfer context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            save_q   <= 1'b0;
            digest_q <= '0;
            base_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values and the update order inside the block is irrelevant.
            state_q  <= state_d;
            idx_q    <= idx_d;
            save_q   <= save_hash;
            digest_q <= digest_d;
            base_q   <= base_d;
        end
    end

    // Next-state logic and output decode from registered state.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        digest_d      = digest_q;
        base_d        = base_q;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        hold_pipeline = 1'b0;
        done          = 1'b0;
        overrun       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cap) begin
                    digest_d = hash_value;
                    base_d   = {dst_addr[31:2], 2'b00};
                    idx_d    = '0;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                mem_we        = 1'b1;
                hold_pipeline = 1'b1;
                overrun       = cap;
                // Address arithmetic is 32-bit and wraps silently past 2^32.
                mem_addr      = base_q + 32'(ADDR_STRIDE) * 32'(idx_q);
                mem_wdata     = digest_q[32 * (NUM_WORDS - 1 - int'(idx_q)) +: 32];
                if (mem_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                hold_pipeline = 1'b1;
                done          = 1'b1;
                // A capture edge landing here is dropped; IDLE is never skipped.
                overrun       = cap;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sm3_hash_store.sv
// tb_sm3_hash_store: table-driven directed transfers, hand-written corner
// sequences and randomized traffic, all checked cycle by cycle against a
// scoreboard of expected memory writes derived from the capture rules.
module tb_sm3_hash_store;

    logic         clk;
    logic         rst;
    logic         save_hash;
    logic [255:0] hash_value;
    logic [31:0]  dst_addr;
    logic         mem_ready;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         hold_pipeline;
    logic         done;
    logic         overrun;

    sm3_hash_store dut (
        .clk           (clk),
        .rst           (rst),
        .save_hash     (save_hash),
        .hash_value    (hash_value),
        .dst_addr      (dst_addr),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .hold_pipeline (hold_pipeline),
        .done          (done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a queue, plus "done is due" flag.
    logic [31:0] m_addr_q[$];
    logic [31:0] m_data_q[$];
    bit          m_done_due;
    bit          m_prev_save;

    // Observations gathered while stepping.
    int          acc_cnt, hold_cnt, done_cnt, over_cnt;
    logic [31:0] acc_addr[$];
    bit          last_done;

    task automatic model_reset();
        m_addr_q.delete();
        m_data_q.delete();
        m_done_due  = 1'b0;
        m_prev_save = 1'b0;
    endtask

    task automatic clear_obs();
        acc_cnt  = 0;
        hold_cnt = 0;
        done_cnt = 0;
        over_cnt = 0;
        acc_addr.delete();
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic step();
        bit cap, busy, nxt_done;
        #1;
        cap  = save_hash && !m_prev_save;
        busy = (m_addr_q.size() != 0) || m_done_due;
        check("mem_we", 32'(mem_we), 32'(m_addr_q.size() != 0));
        check("hold_pipeline", 32'(hold_pipeline), 32'(busy));
        check("done", 32'(done), 32'(m_done_due));
        check("overrun", 32'(overrun), 32'(cap && busy));
        if (m_addr_q.size() != 0) begin
            check("mem_addr", mem_addr, m_addr_q[0]);
            check("mem_wdata", mem_wdata, m_data_q[0]);
        end
        last_done = done;
        if (done) done_cnt++;
        if (hold_pipeline) hold_cnt++;
        if (overrun) over_cnt++;

        nxt_done = 1'b0;
        if (m_addr_q.size() != 0 && mem_ready) begin
            acc_addr.push_back(m_addr_q[0]);
            acc_cnt++;
            void'(m_addr_q.pop_front());
            void'(m_data_q.pop_front());
            if (m_addr_q.size() == 0) nxt_done = 1'b1;
        end
        if (cap && !busy) begin
            for (int i = 0; i < 8; i++) begin
                m_addr_q.push_back((dst_addr & 32'hFFFF_FFFC) + 32'(4 * i));
                m_data_q.push_back(hash_value[255 - 32 * i -: 32]);
            end
        end
        m_done_due  = nxt_done;
        m_prev_save = save_hash;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        check({tag, ".hold"}, 32'(hold_pipeline), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".overrun"}, 32'(overrun), 32'd0);
        check({tag, ".mem_addr"}, mem_addr, 32'd0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    endtask

    typedef struct {
        logic [255:0] hash;
        logic [31:0]  addr;
        int           stall_at;
        int           stall_len;
        logic [31:0]  first_addr;
        logic [31:0]  last_addr;
        int           done_lat;
    } vec_t;

    localparam logic [255:0] ABC =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e4;

    vec_t vecs[4];

    initial begin
        int lat, stalled, guard;

        vecs[0] = '{ABC, 32'h0000_1000, -1, 0, 32'h0000_1000, 32'h0000_101C, 9};
        vecs[1] = '{ABC, 32'h0000_1000, 2, 3, 32'h0000_1000, 32'h0000_101C, 12};
        vecs[2] = '{ABC, 32'hFFFF_FFF6, -1, 0, 32'hFFFF_FFF4, 32'h0000_0010, 9};
        vecs[3] = '{~ABC, 32'h8000_0003, 7, 5, 32'h8000_0000, 32'h8000_001C, 14};

        rst = 1'b0; save_hash = 1'b0; hash_value = '0; dst_addr = '0; mem_ready = 1'b0;
        model_reset();
        clear_obs();
        @(negedge clk);
        @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors: capture, optional stall at one word, measure latency.
        foreach (vecs[v]) begin
            clear_obs();
            save_hash = 1'b1; hash_value = vecs[v].hash; dst_addr = vecs[v].addr; mem_ready = 1'b1;
            step();
            save_hash = 1'b0;
            hash_value = {8{32'hDEAD_BEEF}}; dst_addr = 32'h5555_5555;
            lat = -1; stalled = 0;
            for (int t = 1; t <= 40; t++) begin
                if (acc_cnt == vecs[v].stall_at && stalled < vecs[v].stall_len) begin
                    mem_ready = 1'b0;
                    stalled++;
                end else begin
                    mem_ready = 1'b1;
                end
                step();
                if (last_done) begin
                    lat = t;
                    break;
                end
            end
            check($sformatf("vec%0d.done_lat", v), 32'(lat), 32'(vecs[v].done_lat));
            check($sformatf("vec%0d.hold_cnt", v), 32'(hold_cnt), 32'(vecs[v].done_lat));
            check($sformatf("vec%0d.writes", v), 32'(acc_cnt), 32'd8);
            if (acc_addr.size() == 8) begin
                check($sformatf("vec%0d.first_addr", v), acc_addr[0], vecs[v].first_addr);
                check($sformatf("vec%0d.last_addr", v), acc_addr[7], vecs[v].last_addr);
            end
            step();
        end

        // Level hold: save_hash high for 20 cycles yields exactly one transfer.
        clear_obs();
        save_hash = 1'b1; hash_value = ABC; dst_addr = 32'h0000_2000; mem_ready = 1'b1;
        for (int t = 0; t < 20; t++) step();
        save_hash = 1'b0;
        for (int t = 0; t < 4; t++) step();
        check("level.writes", 32'(acc_cnt), 32'd8);
        check("level.done_cnt", 32'(done_cnt), 32'd1);

        // Overrun during WRITE, then a capture edge landing on the DONE cycle.
        clear_obs();
        save_hash = 1'b1; hash_value = ABC; dst_addr = 32'h0000_3000;
        step();
        step();
        save_hash = 1'b0; step();
        save_hash = 1'b1; hash_value = ~ABC; dst_addr = 32'h0000_7000; step();
        save_hash = 1'b0;
        guard = 0;
        while (acc_cnt < 8 && guard < 40) begin step(); guard++; end
        check("ovr.timeout", 32'(guard < 40), 32'd1);
        save_hash = 1'b1; step();
        for (int t = 0; t < 6; t++) step();
        save_hash = 1'b0; step();
        check("ovr.writes", 32'(acc_cnt), 32'd8);
        check("ovr.overrun_cnt", 32'(over_cnt), 32'd2);
        check("ovr.done_cnt", 32'(done_cnt), 32'd1);

        // Reset mid-transfer at idx=4: outputs clear immediately, nothing resumes.
        clear_obs();
        save_hash = 1'b1; hash_value = ABC; dst_addr = 32'h0000_4000; step();
        save_hash = 1'b0;
        guard = 0;
        while (acc_cnt < 4 && guard < 40) begin step(); guard++; end
        check("rst.timeout", 32'(guard < 40), 32'd1);
        rst = 1'b0;
        #1 check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.hold", 32'(hold_pipeline), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int t = 0; t < 12; t++) step();
        check("rst.writes", 32'(acc_cnt), 32'd4);
        check("rst.done_cnt", 32'(done_cnt), 32'd0);

        // Back-to-back: second rise arrives in the IDLE cycle right after done.
        clear_obs();
        save_hash = 1'b1; hash_value = ABC; dst_addr = 32'h0000_5000; step();
        save_hash = 1'b0;
        guard = 0;
        last_done = 1'b0;
        while (!last_done && guard < 40) begin step(); guard++; end
        check("b2b.timeout", 32'(guard < 40), 32'd1);
        save_hash = 1'b1; hash_value = ~ABC; dst_addr = 32'h0000_6001; step();
        save_hash = 1'b0;
        for (int t = 0; t < 12; t++) step();
        check("b2b.writes", 32'(acc_cnt), 32'd16);
        check("b2b.done_cnt", 32'(done_cnt), 32'd2);
        check("b2b.overrun_cnt", 32'(over_cnt), 32'd0);
        if (acc_addr.size() == 16) check("b2b.second_base", acc_addr[8], 32'h0000_6000);

        // Randomized traffic: toggling save level, random backpressure and data.
        clear_obs();
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 5) == 0) save_hash = ~save_hash;
            hash_value = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
            dst_addr   = $urandom;
            mem_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        save_hash = 1'b0; mem_ready = 1'b1;
        for (int t = 0; t < 40; t++) step();
        check("rand.drained", 32'(m_addr_q.size()), 32'd0);
        check("rand.writes_vs_done", 32'(acc_cnt), 32'(8 * done_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
